ddr_rw_arbiter: RTL and testbench

//  Schedules DDR3 burst traffic for the video frame buffer on clk_100. Drains the write FIFO
//  (wfifo, 128-bit read side) into DDR and refills the read FIFO (rfifo, 128-bit write side)

---
 rtl/ddr_rw_arbiter.sv | 134 +++++++++++++
 tb/tb_ddr_rw_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rw_arbiter.sv
// ddr_rw_arbiter: schedules DDR write/read bursts between frame FIFOs with ping-pong frame banks
module ddr_rw_arbiter #(
  parameter int BURST_LEN   = 64,
  parameter int FRAME_BEATS = 129600,
  parameter int BANK_STRIDE = 'h0200000,
  parameter int ADDR_W      = 28,
  parameter int RD_THRESH   = 1024
) (
  input  logic              clk_100,
  input  logic              rst_h,
  input  logic              ddr_init_done,
  input  logic              wr_load,
  input  logic              rd_load,
  input  logic [10:0]       wfifo_rcount,
  output logic              wfifo_rd_en,
  input  logic [10:0]       rfifo_wcount,
  output logic              rfifo_wr_en,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_wr,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_len,
  input  logic              ddr_wdata_rdy,
  input  logic              ddr_rdata_vld,
  output logic              busy
);
  localparam int OW = $clog2(FRAME_BEATS + 1);
  localparam logic [10:0] BL_C = 11'(BURST_LEN);
  localparam logic [10:0] TH_C = 11'(RD_THRESH);
  localparam logic [7:0] LEN_C = 8'(BURST_LEN - 1);
  localparam logic [OW-1:0] FB_C = OW'(FRAME_BEATS);
  localparam logic [OW-1:0] BLO_C = OW'(BURST_LEN);
  localparam logic [ADDR_W-1:0] STRIDE_C = ADDR_W'(BANK_STRIDE);

  typedef enum logic [2:0] {IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA} state_t;

  state_t state_q, state_d;
  logic wr_load_q, rd_load_q;
  logic [OW-1:0] wr_off_q, wr_off_d, rd_off_q, rd_off_d, wr_nxt, rd_nxt;
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic last_wr_q, last_wr_d, wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic [7:0] beat_q, beat_d, cmd_len_q, cmd_len_d;
  logic cmd_valid_q, cmd_valid_d, cmd_wr_q, cmd_wr_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d, wr_addr, rd_addr;
  logic wr_rise, rd_rise, wr_req, rd_req, grant_wr, grant_rd, wr_dir, rd_dir;
  logic beat_last, wr_end, rd_end, wr_frame, rd_frame;

  assign cmd_valid = cmd_valid_q;
  assign cmd_wr    = cmd_wr_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_len   = cmd_len_q;
  assign busy      = state_q != IDLE;

  // Arbitration, frame/bank bookkeeping and next-state logic
  always_comb begin
    wr_rise     = wr_load & ~wr_load_q;
    rd_rise     = rd_load & ~rd_load_q;
    wr_req      = ddr_init_done & (wfifo_rcount >= BL_C);
    rd_req      = ddr_init_done & (rfifo_wcount < TH_C);
    grant_wr    = state_q == IDLE & wr_req & (~rd_req | ~last_wr_q);
    grant_rd    = state_q == IDLE & rd_req & ~grant_wr;
    wr_dir      = state_q == WR_CMD | state_q == WR_DATA;
    rd_dir      = state_q == RD_CMD | state_q == RD_DATA;
    wfifo_rd_en = state_q == WR_DATA & ddr_wdata_rdy;
    rfifo_wr_en = state_q == RD_DATA & ddr_rdata_vld;
    beat_last   = beat_q == LEN_C;
    wr_end      = wfifo_rd_en & beat_last;
    rd_end      = rfifo_wr_en & beat_last;
    wr_frame    = wr_dir ? wr_end & (wr_pend_q | wr_rise) : wr_rise;
    rd_frame    = rd_dir ? rd_end & (rd_pend_q | rd_rise) : rd_rise;
    wr_pend_d   = wr_dir & ~wr_end & (wr_pend_q | wr_rise);
    rd_pend_d   = rd_dir & ~rd_end & (rd_pend_q | rd_rise);
    wr_nxt      = wr_off_q + BLO_C;
    rd_nxt      = rd_off_q + BLO_C;
    wr_bank_d   = wr_frame ? ~wr_bank_q : wr_bank_q;
    rd_bank_d   = wr_frame ? wr_bank_q : rd_bank_q;
    wr_off_d    = wr_frame ? '0 : wr_end ? (wr_nxt >= FB_C ? '0 : wr_nxt) : wr_off_q;
    rd_off_d    = rd_frame ? '0 : rd_end ? (rd_nxt >= FB_C ? '0 : rd_nxt) : rd_off_q;
    wr_addr     = (wr_bank_d ? STRIDE_C : '0) + ADDR_W'({wr_off_d, 3'b000});
    rd_addr     = (rd_bank_d ? STRIDE_C : '0) + ADDR_W'({rd_off_d, 3'b000});
    beat_d      = (wfifo_rd_en | rfifo_wr_en) ? (beat_last ? '0 : beat_q + 8'd1) : beat_q;
    last_wr_d   = grant_wr ? 1'b1 : grant_rd ? 1'b0 : last_wr_q;
    cmd_wr_d    = (grant_wr | grant_rd) ? grant_wr : cmd_wr_q;
    cmd_addr_d  = grant_wr ? wr_addr : grant_rd ? rd_addr : cmd_addr_q;
    cmd_len_d   = (grant_wr | grant_rd) ? LEN_C : cmd_len_q;
    state_d     = state_q;
    case (state_q)
      IDLE:    state_d = grant_wr ? WR_CMD : grant_rd ? RD_CMD : IDLE;
      WR_CMD:  state_d = cmd_valid_q & cmd_ready ? WR_DATA : WR_CMD;
      WR_DATA: state_d = wr_end ? IDLE : WR_DATA;
      RD_CMD:  state_d = cmd_valid_q & cmd_ready ? RD_DATA : RD_CMD;
      RD_DATA: state_d = rd_end ? IDLE : RD_DATA;
      default: state_d = IDLE;
    endcase
    cmd_valid_d = state_d == WR_CMD | state_d == RD_CMD;
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_100) begin
    if (rst_h) begin
      state_q     <= IDLE;
      wr_load_q   <= 1'b0;
      rd_load_q   <= 1'b0;
      wr_off_q    <= '0;
      rd_off_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b1;
      last_wr_q   <= 1'b0;
      wr_pend_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
      beat_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_load_q   <= wr_load;
      rd_load_q   <= rd_load;
      wr_off_q    <= wr_off_d;
      rd_off_q    <= rd_off_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      last_wr_q   <= last_wr_d;
      wr_pend_q   <= wr_pend_d;
      rd_pend_q   <= rd_pend_d;
      beat_q      <= beat_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
    end
  end
endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// tb_ddr_rw_arbiter: directed scenario tests for ddr_rw_arbiter
module tb_ddr_rw_arbiter;
  localparam logic [27:0] STRIDE = 28'h0200000;
  logic clk_100 = 1'b0;
  logic rst_h = 1'b0, ddr_init_done = 1'b0, wr_load = 1'b0, rd_load = 1'b0;
  logic [10:0] wfifo_rcount = '0, rfifo_wcount = 11'd1500;
  logic cmd_ready = 1'b0, ddr_wdata_rdy = 1'b0, ddr_rdata_vld = 1'b0;
  logic wfifo_rd_en, rfifo_wr_en, cmd_valid, cmd_wr, busy;
  logic [27:0] cmd_addr;
  logic [7:0] cmd_len;
  int checks = 0, errors = 0;

  ddr_rw_arbiter #(.BURST_LEN(64), .FRAME_BEATS(128), .BANK_STRIDE('h0200000), .ADDR_W(28), .RD_THRESH(1024)) dut (
    .clk_100(clk_100), .rst_h(rst_h), .ddr_init_done(ddr_init_done), .wr_load(wr_load), .rd_load(rd_load),
    .wfifo_rcount(wfifo_rcount), .wfifo_rd_en(wfifo_rd_en), .rfifo_wcount(rfifo_wcount), .rfifo_wr_en(rfifo_wr_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .ddr_wdata_rdy(ddr_wdata_rdy), .ddr_rdata_vld(ddr_rdata_vld), .busy(busy)
  );

  always #5 clk_100 = ~clk_100;

  task automatic do_reset();
    wr_load = 1'b0;
    rd_load = 1'b0;
    rst_h = 1'b1;
    repeat (2) @(negedge clk_100);
    rst_h = 1'b0;
  endtask

  // Waits for a command, then counts beats until the burst returns to IDLE; optionally raises wr_load after load_at pops
  task automatic burst(input int load_at, output logic w, output logic [27:0] a, output logic [7:0] l,
                       output int pops, output int pushes, output bit ok);
    int n;
    ok = 1'b0; pops = 0; pushes = 0; w = 1'b0; a = '0; l = '0; n = 0;
    while (!cmd_valid && n < 30) begin
      @(negedge clk_100);
      n++;
    end
    if (!cmd_valid) return;
    w = cmd_wr; a = cmd_addr; l = cmd_len; n = 0;
    do begin
      @(negedge clk_100);
      pops += int'(wfifo_rd_en);
      pushes += int'(rfifo_wr_en);
      if (pops == load_at) wr_load = 1'b1;
      n++;
    end while (busy && n < 300);
    ok = !busy;
  endtask

  task automatic test_reset();
    ddr_init_done = 1'b1; wfifo_rcount = 11'd200; rfifo_wcount = 11'd0;
    do_reset();
    ddr_init_done = 1'b0;
    checks++;
    if ({cmd_valid, wfifo_rd_en, rfifo_wr_en, busy, cmd_wr} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {cmd_valid, wfifo_rd_en, rfifo_wr_en, busy, cmd_wr});
    end
    checks++;
    if ({cmd_addr, cmd_len} !== 36'h0) begin
      errors++; $display("FAIL reset_cmd got addr %h len %h want 0 0", cmd_addr, cmd_len);
    end
    repeat (6) @(negedge clk_100);
    checks++;
    if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
      errors++; $display("FAIL init_gate got busy %b valid %b want 0 0", busy, cmd_valid);
    end
  endtask

  task automatic test_thresholds();
    ddr_init_done = 1'b1; wfifo_rcount = 11'd63; rfifo_wcount = 11'd1024;
    repeat (8) @(negedge clk_100);
    checks++;
    if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
      errors++; $display("FAIL threshold_idle got busy %b valid %b want 0 0", busy, cmd_valid);
    end
  endtask

  task automatic test_write_wrap();
    logic w; logic [27:0] a; logic [7:0] l; int p, q; bit ok;
    logic [27:0] exp_a [3] = '{28'd0, 28'd512, 28'd0};
    do_reset();
    ddr_init_done = 1'b1; wfifo_rcount = 11'd64; rfifo_wcount = 11'd1500;
    cmd_ready = 1'b1; ddr_wdata_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      burst(-1, w, a, l, p, q, ok);
      if (i == 2) wfifo_rcount = 11'd0;
      checks++;
      if (!ok || w !== 1'b1 || a !== exp_a[i] || l !== 8'd63 || p != 64 || q != 0) begin
        errors++;
        $display("FAIL write_burst%0d got ok %0d wr %b addr %h len %0d pops %0d pushes %0d want 1 1 %h 63 64 0",
                 i, ok, w, a, l, p, q, exp_a[i]);
      end
    end
    repeat (4) @(negedge clk_100);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL write_drained got busy %b want 0", busy);
    end
  endtask

  task automatic test_contention();
    logic w; logic [27:0] a; logic [7:0] l; int p, q; bit ok;
    logic       exp_w [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [27:0] exp_a [5] = '{28'd0, STRIDE, 28'd512, STRIDE + 28'd512, 28'd0};
    do_reset();
    ddr_init_done = 1'b1; wfifo_rcount = 11'd200; rfifo_wcount = 11'd0;
    cmd_ready = 1'b1; ddr_wdata_rdy = 1'b1; ddr_rdata_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      burst(-1, w, a, l, p, q, ok);
      if (i == 4) begin wfifo_rcount = 11'd0; rfifo_wcount = 11'd1500; end
      checks++;
      if (!ok || w !== exp_w[i] || a !== exp_a[i] || p != (exp_w[i] ? 64 : 0) || q != (exp_w[i] ? 0 : 64)) begin
        errors++;
        $display("FAIL contention%0d got ok %0d wr %b addr %h pops %0d pushes %0d want wr %b addr %h",
                 i, ok, w, a, p, q, exp_w[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_frame_switch();
    logic w; logic [27:0] a; logic [7:0] l; int p, q; bit ok;
    do_reset();
    ddr_init_done = 1'b1; wfifo_rcount = 11'd0; rfifo_wcount = 11'd0;
    cmd_ready = 1'b1; ddr_wdata_rdy = 1'b1; ddr_rdata_vld = 1'b1;
    burst(-1, w, a, l, p, q, ok);
    rfifo_wcount = 11'd1500; wfifo_rcount = 11'd64;
    checks++;
    if (!ok || w !== 1'b0 || a !== STRIDE || q != 64) begin
      errors++; $display("FAIL frame_first_read got ok %0d wr %b addr %h pushes %0d want 1 0 %h 64", ok, w, a, q, STRIDE);
    end
    burst(10, w, a, l, p, q, ok);
    wr_load = 1'b0;
    checks++;
    if (!ok || w !== 1'b1 || a !== 28'd0 || p != 64) begin
      errors++; $display("FAIL frame_old_write got ok %0d wr %b addr %h pops %0d want 1 1 0 64", ok, w, a, p);
    end
    burst(-1, w, a, l, p, q, ok);
    wfifo_rcount = 11'd0;
    checks++;
    if (!ok || w !== 1'b1 || a !== STRIDE) begin
      errors++; $display("FAIL frame_new_bank got ok %0d wr %b addr %h want 1 1 %h", ok, w, a, STRIDE);
    end
    @(negedge clk_100);
    rd_load = 1'b1;
    @(negedge clk_100);
    rd_load = 1'b0;
    rfifo_wcount = 11'd0;
    burst(-1, w, a, l, p, q, ok);
    rfifo_wcount = 11'd1500;
    checks++;
    if (!ok || w !== 1'b0 || a !== 28'd0 || q != 64) begin
      errors++; $display("FAIL frame_read_bank0 got ok %0d wr %b addr %h pushes %0d want 1 0 0 64", ok, w, a, q);
    end
  endtask

  task automatic test_stall_reset();
    logic w; logic [27:0] a; logic [7:0] l; int p, q, n, bad; bit ok;
    do_reset();
    ddr_init_done = 1'b1; wfifo_rcount = 11'd64; rfifo_wcount = 11'd1500;
    cmd_ready = 1'b0; ddr_wdata_rdy = 1'b1; ddr_rdata_vld = 1'b1;
    repeat (2) @(negedge clk_100);
    a = cmd_addr; bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (cmd_valid !== 1'b1 || cmd_addr !== a || cmd_wr !== 1'b1 || wfifo_rd_en !== 1'b0) bad++;
      @(negedge clk_100);
    end
    checks++;
    if (bad != 0 || a !== 28'd0) begin
      errors++; $display("FAIL stall_stable got %0d unstable cycles addr %h want 0 unstable addr 0", bad, a);
    end
    cmd_ready = 1'b1;
    burst(-1, w, a, l, p, q, ok);
    wfifo_rcount = 11'd0; rfifo_wcount = 11'd0;
    checks++;
    if (!ok || w !== 1'b1 || a !== 28'd0 || p != 64) begin
      errors++; $display("FAIL stall_release got ok %0d wr %b addr %h pops %0d want 1 1 0 64", ok, w, a, p);
    end
    n = 0;
    while (!rfifo_wr_en && n < 30) begin
      @(negedge clk_100);
      n++;
    end
    checks++;
    if (rfifo_wr_en !== 1'b1) begin
      errors++; $display("FAIL read_start got rfifo_wr_en %b want 1", rfifo_wr_en);
    end
    repeat (5) @(negedge clk_100);
    rst_h = 1'b1;
    @(negedge clk_100);
    checks++;
    if (rfifo_wr_en !== 1'b0 || busy !== 1'b0 || cmd_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_read got wr_en %b busy %b valid %b want 0 0 0", rfifo_wr_en, busy, cmd_valid);
    end
    rfifo_wcount = 11'd1500;
    rst_h = 1'b0;
  endtask

  initial begin
    @(negedge clk_100);
    test_reset();
    test_thresholds();
    test_write_wrap();
    test_contention();
    test_frame_switch();
    test_stall_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
